// File: rtl/uart_note_queue.sv
// Byte-driven note sequencer: queues UART note/duration bytes and plays them as timed notes.
// Optional: define UART_NOTE_QUEUE_GAP_EN to insert a 10 ms silence after every note.
module uart_note_queue #(
   parameter int CLK_FREQ = 12000000,
   parameter int DEPTH    = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     rx_done,
   input  logic [7:0]               rx_data,
   input  logic                     play_en,
   output logic [4:0]               note_out,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int TICK_DIV = CLK_FREQ / 1000;
   localparam int PW       = $clog2(DEPTH);
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MW       = 12;

`ifdef UART_NOTE_QUEUE_GAP_EN
   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

   function automatic logic [MW-1:0] dur_ms(input logic [2:0] dur);
      case (dur)
         3'd2:    dur_ms = MW'(500);
         3'd3:    dur_ms = MW'(1000);
         3'd4:    dur_ms = MW'(2000);
         3'd5:    dur_ms = MW'(4000);
         default: dur_ms = MW'(200);
      endcase
   endfunction

   state_t          state;
   logic            rx_d0, rx_d1;
   logic [7:0]      rx_byte;
   logic [7:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]      rd_entry;
   logic [MW-1:0]   ms_len, ms_cnt;
   logic [TW-1:0]   tick_cnt;
   logic            byte_evt, flush, wr_req, full, pop, wr_en, wr_drop, tick_last;

   // Stage 0: rx_done edge detection; the byte is captured while rx_done is high
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_d0 <= 1'b0;
         rx_d1 <= 1'b0;
      end else begin
         rx_d0 <= rx_done;
         rx_d1 <= rx_d0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rx_done) rx_byte <= rx_data;
   end

   assign byte_evt  = rx_d0 & ~rx_d1;
   assign flush     = byte_evt & (rx_byte[2:0] == 3'd0);
   assign wr_req    = byte_evt & (rx_byte[2:0] != 3'd0);
   assign full      = (fifo_count == (PW+1)'(DEPTH));
   assign pop       = (state == LOAD) & (fifo_count != '0) & ~flush;
   assign wr_en     = wr_req & (~full | pop);
   assign wr_drop   = wr_req & full & ~pop;
   assign rd_entry  = mem[rd_ptr];
   assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
   assign busy      = (state != IDLE);

   // Stage 1: FIFO storage and bookkeeping
   always_ff @(posedge sys_clk) begin
      if (wr_en) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (wr_drop) overflow <= 1'b1;
      end
   end

   // Stage 2: playback FSM; flush outranks play_en, which outranks timing
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         note_out <= 5'd0;
         ms_len   <= '0;
         ms_cnt   <= '0;
         tick_cnt <= '0;
      end else if (flush) begin
         state    <= IDLE;
         note_out <= 5'd0;
         ms_cnt   <= '0;
         tick_cnt <= '0;
      end else if (state != IDLE && !play_en) begin
         state    <= IDLE;
         note_out <= 5'd0;
         ms_cnt   <= '0;
         tick_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               note_out <= 5'd0;
               if (play_en && fifo_count != '0) state <= LOAD;
            end
            LOAD: begin
               note_out <= rd_entry[7:3];
               ms_len   <= dur_ms(rd_entry[2:0]);
               ms_cnt   <= '0;
               tick_cnt <= '0;
               state    <= PLAY;
            end
            PLAY: begin
               if (tick_last) begin
                  tick_cnt <= '0;
                  if (ms_cnt == ms_len - 1'b1) begin
                     ms_cnt <= '0;
`ifdef UART_NOTE_QUEUE_GAP_EN
                     state    <= GAP;
                     note_out <= 5'd0;
`else
                     if (fifo_count != '0) begin
                        state <= LOAD;
                     end else begin
                        state    <= IDLE;
                        note_out <= 5'd0;
                     end
`endif
                  end else begin
                     ms_cnt <= ms_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
`ifdef UART_NOTE_QUEUE_GAP_EN
            GAP: begin
               note_out <= 5'd0;
               if (tick_last) begin
                  tick_cnt <= '0;
                  if (ms_cnt == MW'(9)) begin
                     ms_cnt <= '0;
                     state  <= (fifo_count != '0) ? LOAD : IDLE;
                  end else begin
                     ms_cnt <= ms_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               note_out <= 5'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_note_queue.sv
// Directed bench for uart_note_queue at CLK_FREQ=10000 (10 cycles per ms), DEPTH=4.
module tb_uart_note_queue;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       play_en;
   logic [4:0] note_out;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   int checks = 0;
   int failures = 0;

`ifdef UART_NOTE_QUEUE_GAP_EN
   localparam int GAP_CYC = 100;
   localparam int RUN4    = 8000;
`else
   localparam int GAP_CYC = 0;
   localparam int RUN4    = 8003;
`endif

   uart_note_queue #(.CLK_FREQ(10000), .DEPTH(4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .rx_done    (rx_done),
      .rx_data    (rx_data),
      .play_en    (play_en),
      .note_out   (note_out),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      cyc(1);
      rx_done = 1'b0;
      cyc(1);
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0;
      rx_done   = 1'b0;
      rx_data   = 8'h00;
      play_en   = 1'b0;
      cyc(3);
      checks++; if (note_out !== 5'd0) begin failures++; $display("FAIL reset_note: got %0d expected 0", note_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      sys_rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_single_note;
      int run;
      play_en = 1'b1;
      send_byte(8'h31);
      for (int i = 0; i < 20 && note_out == 5'd0; i++) cyc(1);
      checks++; if (note_out !== 5'd6) begin failures++; $display("FAIL single_note_value: got %0d expected 6", note_out); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_note_busy: got %0b expected 1", busy); end
      run = 0;
      for (int i = 0; i < 3000 && note_out == 5'd6; i++) begin
         run++;
         cyc(1);
      end
      checks++; if (run != 2000) begin failures++; $display("FAIL single_note_len: got %0d expected 2000", run); end
      checks++; if (note_out !== 5'd0) begin failures++; $display("FAIL single_note_after: got %0d expected 0", note_out); end
      cyc(GAP_CYC + 2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_note_idle: got %0b expected 0", busy); end
      play_en = 1'b0;
   endtask

   task automatic test_held_rx;
      int maxc;
      maxc = 0;
      rx_data = 8'h0A;
      rx_done = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      end
      rx_done = 1'b0;
      cyc(3);
      checks++; if (maxc != 1) begin failures++; $display("FAIL held_rx_max: got %0d expected 1", maxc); end
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL held_rx_count: got %0d expected 1", fifo_count); end
      send_byte(8'h00);
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL held_rx_flush: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_overflow_order;
      int run;
      play_en = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(8'h09);
      cyc(2);
      checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
      play_en = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) cyc(1);
      run = 0;
      for (int i = 0; i < 12000 && busy; i++) begin
         if (note_out == 5'd1) run++;
         cyc(1);
      end
      checks++; if (run != RUN4) begin failures++; $display("FAIL ovf_play_cycles: got %0d expected %0d", run, RUN4); end
      checks++; if (busy !== 1'b0 || note_out !== 5'd0) begin failures++; $display("FAIL ovf_idle: got busy=%0b note=%0d expected busy=0 note=0", busy, note_out); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL ovf_drained: got %0d expected 0", fifo_count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
      play_en = 1'b0;
      send_byte(8'h00);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flush_clear: got %0b expected 0", overflow); end
   endtask

   task automatic test_flush_mid;
      play_en = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(8'h09);
      play_en = 1'b1;
      for (int i = 0; i < 10 && note_out != 5'd1; i++) cyc(1);
      cyc(100);
      checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL flush_pre_count: got %0d expected 3", fifo_count); end
      send_byte(8'hF8);
      checks++; if (note_out !== 5'd0) begin failures++; $display("FAIL flush_note: got %0d expected 0", note_out); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow: got %0b expected 0", overflow); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %0b expected 0", busy); end
      cyc(20);
      checks++; if (busy !== 1'b0 || note_out !== 5'd0) begin failures++; $display("FAIL flush_stays_idle: got busy=%0b note=%0d expected busy=0 note=0", busy, note_out); end
      play_en = 1'b0;
   endtask

   task automatic test_full_pop_wrap;
      int rec[$];
      play_en = 1'b0;
      for (int n = 1; n <= 4; n++) send_byte(8'((n << 3) | 1));
      checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL wrap_full: got %0d expected 4", fifo_count); end
      fork
         begin
            play_en = 1'b1;
            send_byte(8'((5 << 3) | 1));
            checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL wrap_pop_write_count: got %0d expected 4", fifo_count); end
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_pop_write_ovf: got %0b expected 0", overflow); end
            for (int n = 6; n <= 12; n++) begin
               for (int w = 0; w < 5000 && fifo_count == 3'd4; w++) cyc(1);
               send_byte(8'((n << 3) | 1));
            end
         end
         begin
            logic [4:0] last;
            last = 5'd0;
            for (int c = 0; c < 32000 && rec.size() < 12; c++) begin
               cyc(1);
               if (note_out != 5'd0 && note_out != last) begin
                  rec.push_back(int'(note_out));
                  last = note_out;
               end
            end
         end
      join
      checks++; if (rec.size() != 12) begin failures++; $display("FAIL wrap_note_total: got %0d expected 12", rec.size()); end
      for (int i = 0; i < rec.size(); i++) begin
         checks++; if (rec[i] != i + 1) begin failures++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, rec[i], i + 1); end
      end
      for (int i = 0; i < 5000 && busy; i++) cyc(1);
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL wrap_end: got busy=%0b count=%0d expected busy=0 count=0", busy, fifo_count); end
      play_en = 1'b0;
   endtask

   task automatic test_reset_mid;
      play_en = 1'b1;
      send_byte(8'h2D);
      for (int i = 0; i < 10 && note_out != 5'd5; i++) cyc(1);
      checks++; if (note_out !== 5'd5) begin failures++; $display("FAIL rstmid_playing: got %0d expected 5", note_out); end
      cyc(50);
      send_byte(8'h11);
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL rstmid_queued: got %0d expected 1", fifo_count); end
      #3;
      sys_rst_n = 1'b0;
      #1;
      checks++; if (note_out !== 5'd0) begin failures++; $display("FAIL rstmid_async_note: got %0d expected 0", note_out); end
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL rstmid_outputs: got busy=%0b count=%0d ovf=%0b expected 0 0 0", busy, fifo_count, overflow); end
      cyc(3);
      sys_rst_n = 1'b1;
      cyc(50);
      checks++; if (busy !== 1'b0 || note_out !== 5'd0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rstmid_silent: got busy=%0b note=%0d count=%0d expected 0 0 0", busy, note_out, fifo_count); end
      send_byte(8'h19);
      for (int i = 0; i < 20 && note_out != 5'd3; i++) cyc(1);
      checks++; if (note_out !== 5'd3) begin failures++; $display("FAIL rstmid_new_note: got %0d expected 3", note_out); end
   endtask

   initial begin
      test_reset;
      test_single_note;
      test_held_rx;
      test_overflow_order;
      test_flush_mid;
      test_full_pop_wrap;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_note_queue.md
UART_NOTE_QUEUE -- requirements
Module: uart_note_queue

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, 4..64.
REQ-003 SHALL have localparam TICK_DIV = CLK_FREQ/1000, the cycles per 1 ms.
REQ-004 SHALL have port sys_clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port rx_done, input, 1, UART receiver byte-done level/pulse, may stay high for several cycles.
REQ-007 SHALL have port rx_data, input, 8, received byte, stable while rx_done high.
REQ-008 SHALL have port play_en, input, 1, playback enable.
REQ-009 SHALL have port note_out, output, 5, note index to tone generator; 0 means silence.
REQ-010 SHALL have port busy, output, 1, high while in LOAD, PLAY or GAP.
REQ-011 SHALL have port fifo_count, output, $clog2(DEPTH)+1, current number of stored entries.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-013 SHALL register rx_done twice (d0, d1) and treat d0 & ~d1 as one byte event; a held-high rx_done SHALL yield exactly one event.
REQ-014 SHALL decode each byte as note = rx_data[7:3] and dur = rx_data[2:0].
REQ-015 SHALL map dur to ms as follows: 1 -> 200, 2 -> 500, 3 -> 1000, 4 -> 2000, 5 -> 4000, 6 or 7 -> 200.
REQ-016 SHALL treat dur = 0 as FLUSH, never stored: empty the FIFO, clear overflow, abort the current note, set note_out = 0, enter IDLE, all on the event cycle.
REQ-017 SHALL write each non-FLUSH byte on its event cycle; fifo_count SHALL increment on the following clock edge.
REQ-018 SHALL drop the byte when the FIFO is full with no pop in the same cycle, and set overflow.
REQ-019 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle; fifo_count SHALL stay unchanged.
REQ-020 SHALL implement read/write pointers modulo DEPTH that wrap without loss.
REQ-021 SHALL implement FSM states IDLE, LOAD, PLAY, GAP.
REQ-022 IDLE: note_out = 0; SHALL go to LOAD when play_en = 1 and fifo_count != 0.
REQ-023 LOAD: SHALL pop one entry, latch note and duration, and go to PLAY in exactly 1 cycle.
REQ-024 PLAY: note_out SHALL equal the latched note from the first PLAY cycle for exactly ms*TICK_DIV cycles, counted by a ms counter and a tick counter both cleared on entry.
REQ-025 SHALL leave PLAY at the end of the duration to GAP (if NOTE_GAP_EN), else to LOAD if FIFO non-empty, else to IDLE.
REQ-026 SHALL, when play_en goes low in LOAD, PLAY or GAP, enter IDLE on the next edge with note_out = 0; an entry already popped is discarded and FIFO contents are kept.
REQ-027 SHALL give FLUSH priority over every FSM transition on the same cycle.
REQ-028 SHALL play a note = 0 entry as a timed rest.

Reset
REQ-029 On sys_rst_n = 0, SHALL set: state IDLE, note_out 0, busy 0, fifo_count 0, overflow 0, pointers 0, counters 0, d0 and d1 0.
REQ-030 Reset mid-note SHALL silence note_out immediately (asynchronous) and discard all FIFO contents.

Configuration
REQ-031 With macro UART_NOTE_QUEUE_GAP_EN (NOTE_GAP_EN) defined, after each PLAY the block SHALL hold GAP for 10*TICK_DIV cycles with note_out = 0, then go to LOAD if FIFO non-empty, else to IDLE.
REQ-032 Without UART_NOTE_QUEUE_GAP_EN, the GAP state and its counter SHALL be absent, and consecutive notes SHALL be back-to-back (PLAY -> LOAD -> PLAY, with 1 cycle of the previous note held during LOAD).

Verification (CLK_FREQ=10000, TICK_DIV=10, DEPTH=4)
REQ-033 Byte 0x31 (note 6, dur 1) with play_en = 1 -> note_out = 6 for exactly 2000 cycles, then 0; busy returns low (plus 100 cycles of gap when GAP_EN).
REQ-034 rx_done held high 50 cycles with byte 0x0A -> fifo_count goes to 1 once, never 2.
REQ-035 play_en = 0, five bytes 0x09 -> fifo_count = 4 and overflow = 1; then play_en = 1 -> four notes of 1 play in order, then idle.
REQ-036 Mid-note byte 0xF8 (FLUSH) with 3 queued -> next cycle note_out = 0, fifo_count = 0, overflow = 0, state IDLE.
REQ-037 FIFO full with a pop in the same cycle as a write -> fifo_count stays 4, no overflow; pointer wrap verified over 12 bytes, output order preserved.
REQ-038 sys_rst_n pulsed low during a dur 5 note -> note_out = 0 asynchronously, all outputs at reset values, no note after release until new bytes arrive.
